voice_allocator: RTL

//  Event-side driver for a bank of adsr envelope generators. Accepts note-on/note-off

---
 rtl/synth_pkg.sv | 34 +++
 rtl/voice_allocator_pick.sv | 102 ++++++++++
 rtl/voice_allocator.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
//   Shared types for the voice allocator: note/voice/age scalar types, the
//   latched note event and the one-hot allocator FSM state.
//   The DEF_* constants are the default widths.
//   voice_allocator's parameters default to these constants.
//   The event struct is sized by DEF_NOTE_BITS, so NOTE_BITS must stay equal
//   to DEF_NOTE_BITS.
// -----------------------------------------------------------------------------
package synth_pkg;

    localparam int DEF_VOICES    = 8;
    localparam int DEF_NOTE_BITS = 7;
    localparam int DEF_AGE_BITS  = 8;
    localparam int DEF_VIDX      = $clog2(DEF_VOICES);

    typedef logic [DEF_NOTE_BITS-1:0] note_t;
    typedef logic [DEF_VIDX-1:0]      voice_idx_t;
    typedef logic [DEF_AGE_BITS-1:0]  age_t;

    // Note event as latched on the accept edge.
    typedef struct packed {
        logic  on;
        note_t note;
    } event_t;

    // Allocator FSM state, one-hot.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SEARCH = 3'b010,
        ST_RETRIG = 3'b100
    } state_t;

endpackage

// File: rtl/voice_allocator_pick.sv
// -----------------------------------------------------------------------------
// voice_allocator_pick (voice_pick)
//   Combinational victim selection for a note-on.
//   Priority, highest first:
//     1) gated voice already holding ev_note (retrigger)
//     2) lowest index with gate=0, active=0 (free)
//     3) lowest index with gate=0, active=1 (releasing)
//     4) gated voice with maximum age, ties to lowest index
//        (present only when VOICE_ALLOC_STEAL_EN is defined)
//   Ports:
//     gate, active   per-voice gate and adsr-active vectors
//     notes          per-voice note numbers
//     ages           per-voice allocation ages (VOICE_ALLOC_STEAL_EN only)
//     ev_note        note being allocated
//     hit            a victim was found
//     victim         victim voice index
//     victim_gated   victim currently has gate=1 (needs the retrigger cycle)
//   Macro: VOICE_ALLOC_STEAL_EN enables priority 4.
// -----------------------------------------------------------------------------
module voice_allocator_pick #(
    parameter int VOICES    = 8,
    parameter int NOTE_BITS = 7,
`ifdef VOICE_ALLOC_STEAL_EN
    parameter int AGE_BITS  = 8,
`endif
    parameter int VIDX      = $clog2(VOICES)
) (
    input  logic [VOICES-1:0]                gate,
    input  logic [VOICES-1:0]                active,
    input  logic [VOICES-1:0][NOTE_BITS-1:0] notes,
`ifdef VOICE_ALLOC_STEAL_EN
    input  logic [VOICES-1:0][AGE_BITS-1:0]  ages,
`endif
    input  logic [NOTE_BITS-1:0]             ev_note,
    output logic                             hit,
    output logic [VIDX-1:0]                  victim,
    output logic                             victim_gated
);

    logic            rt_hit,   free_hit,   rel_hit;
    logic [VIDX-1:0] rt_idx,   free_idx,   rel_idx;
`ifdef VOICE_ALLOC_STEAL_EN
    logic                old_hit;
    logic [VIDX-1:0]     old_idx;
    logic [AGE_BITS-1:0] old_age;
`endif

    always_comb begin
        rt_hit   = 1'b0;  rt_idx   = '0;
        free_hit = 1'b0;  free_idx = '0;
        rel_hit  = 1'b0;  rel_idx  = '0;
        // Scanning downward lets the lowest matching index win.
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (gate[i] && (notes[i] == ev_note)) begin
                rt_hit = 1'b1;
                rt_idx = VIDX'(i);
            end
            if (!gate[i] && !active[i]) begin
                free_hit = 1'b1;
                free_idx = VIDX'(i);
            end
            if (!gate[i] && active[i]) begin
                rel_hit = 1'b1;
                rel_idx = VIDX'(i);
            end
        end

`ifdef VOICE_ALLOC_STEAL_EN
        old_hit = 1'b0;
        old_idx = '0;
        old_age = '0;
        // Strict '>' while scanning upward keeps ties on the lowest index.
        for (int i = 0; i < VOICES; i++) begin
            if (gate[i] && (!old_hit || (ages[i] > old_age))) begin
                old_hit = 1'b1;
                old_idx = VIDX'(i);
                old_age = ages[i];
            end
        end
`endif

        hit          = 1'b1;
        victim       = '0;
        victim_gated = 1'b0;
        if (rt_hit) begin
            victim       = rt_idx;
            victim_gated = 1'b1;
        end else if (free_hit) begin
            victim = free_idx;
        end else if (rel_hit) begin
            victim = rel_idx;
`ifdef VOICE_ALLOC_STEAL_EN
        end else if (old_hit) begin
            victim       = old_idx;
            victim_gated = 1'b1;
`endif
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//   Assigns note-on/note-off events to a bank of VOICES adsr voices and drives
//   each voice's gate and note.
//   Ports:
//     clk, reset     clock; asynchronous active-high reset
//     ev_valid/ev_ready/ev_on/ev_note
//                    event handshake; accepted on an edge with both high
//     voice_active   per-voice adsr active flags
//     voice_gate     per-voice adsr gate
//     voice_note     per-voice note; voice i at [i*NOTE_BITS +: NOTE_BITS]
//     alloc_valid    one-cycle pulse: a note-on landed on alloc_voice
//     alloc_voice    voice of the most recent allocation
//     ev_dropped     one-cycle pulse: a note-on found no voice
//     dbg_state      current FSM state (one-hot state_t encoding)
//   Handshake: an event transfers on a rising clk edge where ev_valid and
//   ev_ready are both 1. ev_ready is combinational (state == IDLE) and does not
//   depend on ev_valid. The event fields must be stable while ev_valid is high.
//   Macro: VOICE_ALLOC_STEAL_EN enables stealing the oldest gated voice.
//   Without it, unplaceable note-ons are dropped and no age state exists.
// -----------------------------------------------------------------------------
module voice_allocator
    import synth_pkg::*;
#(
    parameter int VOICES    = DEF_VOICES,
    parameter int NOTE_BITS = DEF_NOTE_BITS,
    parameter int AGE_BITS  = DEF_AGE_BITS,
    localparam int VIDX     = $clog2(VOICES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_on,
    input  logic [NOTE_BITS-1:0]      ev_note,
    input  logic [VOICES-1:0]         voice_active,
    output logic [VOICES-1:0]         voice_gate,
    output logic [VOICES*NOTE_BITS-1:0] voice_note,
    output logic                      alloc_valid,
    output logic [VIDX-1:0]           alloc_voice,
    output logic                      ev_dropped,
    output logic [2:0]                dbg_state
);

    state_t                          state;
    event_t                          ev_q;
    logic [VOICES-1:0]               gate_q;
    logic [VOICES-1:0][NOTE_BITS-1:0] note_q;
    logic [VIDX-1:0]                 rtg_voice;

    logic                            pick_hit;
    logic [VIDX-1:0]                 pick_victim;
    logic                            pick_gated;

`ifdef VOICE_ALLOC_STEAL_EN
    logic [VOICES-1:0][AGE_BITS-1:0] age_q;
`endif

    assign ev_ready   = (state == ST_IDLE);
    assign voice_gate = gate_q;
    assign voice_note = note_q;
    assign dbg_state  = state;

    voice_allocator_pick #(
        .VOICES    (VOICES),
        .NOTE_BITS (NOTE_BITS),
`ifdef VOICE_ALLOC_STEAL_EN
        .AGE_BITS  (AGE_BITS),
`endif
        .VIDX      (VIDX)
    ) u_pick (
        .gate         (gate_q),
        .active       (voice_active),
        .notes        (note_q),
`ifdef VOICE_ALLOC_STEAL_EN
        .ages         (age_q),
`endif
        .ev_note      (ev_q.note),
        .hit          (pick_hit),
        .victim       (pick_victim),
        .victim_gated (pick_gated)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ev_q        <= '0;
            gate_q      <= '0;
            note_q      <= '0;
            rtg_voice   <= '0;
            alloc_valid <= 1'b0;
            alloc_voice <= '0;
            ev_dropped  <= 1'b0;
`ifdef VOICE_ALLOC_STEAL_EN
            age_q       <= '0;
`endif
        end else begin
            alloc_valid <= 1'b0;
            ev_dropped  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ev_valid) begin
                        ev_q  <= '{on: ev_on, note: ev_note};
                        state <= ST_SEARCH;
                    end
                end

                ST_SEARCH: begin
                    state <= ST_IDLE;
                    if (!ev_q.on) begin
                        // Note-off releases every gated voice playing the note.
                        for (int i = 0; i < VOICES; i++) begin
                            if (gate_q[i] && (note_q[i] == ev_q.note))
                                gate_q[i] <= 1'b0;
                        end
                    end else if (pick_hit) begin
                        note_q[pick_victim] <= ev_q.note;
`ifdef VOICE_ALLOC_STEAL_EN
                        for (int i = 0; i < VOICES; i++) begin
                            if (VIDX'(i) == pick_victim)
                                age_q[i] <= '0;
                            else if (gate_q[i] && (age_q[i] != '1))
                                age_q[i] <= age_q[i] + 1'b1;
                        end
`endif
                        if (pick_gated) begin
                            // Drop the gate for one cycle so the adsr restarts its attack.
                            gate_q[pick_victim] <= 1'b0;
                            rtg_voice           <= pick_victim;
                            state               <= ST_RETRIG;
                        end else begin
                            gate_q[pick_victim] <= 1'b1;
                            alloc_valid         <= 1'b1;
                            alloc_voice         <= pick_victim;
                        end
                    end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                        ev_dropped <= 1'b0;
`else
                        ev_dropped <= 1'b1;
`endif
                    end
                end

                ST_RETRIG: begin
                    gate_q[rtg_voice] <= 1'b1;
                    alloc_valid       <= 1'b1;
                    alloc_voice       <= rtg_voice;
                    state             <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
